bidshift_stepper: RTL
=====================

# bidshift_stepper

Parametrised bidirectional shift register for the handball playfield LED row. It moves the ball pattern left or right at a programmable step rate set by an internal prescaler. It also reports bits shifted off either end, keeps a sticky "ball lost" flag and a move counter, and supports optional wrap-around rotation. It sits between the game-control FSM (drives SEL/SIL/SIR/SRIN) and the LED driver (consumes SROUT).

## Interface
- WIDTH, 8, register width in bits (>= 2)
- DIV, 4, CK cycles per shift step (>= 1)
- MOVE_W, 8, width of move counter
- CK  in  1  clock, rising edge
- CLEAR  in  1  asynchronous, active-low reset
- SRIN  in  WIDTH  parallel load data
- SEL  in  2  00 hold, 01 shift right, 10 shift left, 11 load
- SIL  in  1  serial in at LSB on left shift
- SIR  in  1  serial in at MSB on right shift
- ROT  in  1  rotate request (used only with BIDSHIFT_ROTATE_EN)
- SROUT  out  WIDTH  register contents
- SOR  out  1  one-cycle pulse: value of bit shifted out of LSB on a right step
- SOL  out  1  one-cycle pulse: value of bit shifted out of MSB on a left step
- STEP  out  1  one-cycle pulse: a shift was performed
- LOST  out  1  sticky: a 1 was shifted off either end
- MOVES  out  MOVE_W  shifts since last load, saturating

## Operation
- Reset (CLEAR=0, any time, asynchronous): SROUT=0, SOR=SOL=STEP=0, LOST=0, MOVES=0, prescaler=0. Any operation in progress is abandoned.
- Prescaler counts 0..DIV-1 only while SEL is 01 or 10. When it is at DIV-1 (step cycle), the shift executes and the prescaler returns to 0. DIV=1 gives a step every cycle.
- SEL=00: SROUT, LOST, MOVES and prescaler all hold. SOR/SOL/STEP are 0.
- SEL=01, step cycle: SROUT <= {SIR, SROUT[WIDTH-1:1]}; SOR <= SROUT[0]; STEP <= 1.
- SEL=10, step cycle: SROUT <= {SROUT[WIDTH-2:0], SIL}; SOL <= SROUT[WIDTH-1]; STEP <= 1.
- Non-step shift cycle: SROUT holds; pulses are 0.
- SEL=11: SROUT <= SRIN immediately, independent of the prescaler. Prescaler <= 0, MOVES <= 0, LOST <= 0. Pulses are 0.
- LOST is set on any step whose outgoing bit is 1. It clears only on load or reset.
- MOVES increments on every step and saturates at 2^MOVE_W-1.
- Changing direction mid-count (01 to 10) keeps the prescaler value. No restart.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- A step is visible on SROUT one CK edge after the step cycle. SOR/SOL/STEP pulse in that same cycle, for exactly one cycle.
- Load is visible one edge after SEL=11 is sampled.
- After a load followed by continuous shifting, the first step lands on the DIV-th shift cycle.
- Deassertion of CLEAR is synchronised by the system reset tree. The block needs no extra synchroniser.

## Configuration
- BIDSHIFT_ROTATE_EN defined:
  - With ROT=1, a right step feeds SROUT[0] into the MSB and a left step feeds SROUT[WIDTH-1] into the LSB. SIL/SIR are ignored.
  - SOR/SOL still pulse with the wrapped bit.
  - LOST is not set by rotating steps.
- BIDSHIFT_ROTATE_EN undefined: ROT is ignored. Serial inputs are always SIL/SIR.

## Structure
- Package bidshift_pkg holds:
  - the SEL encodings SEL_HOLD=2'b00, SEL_RIGHT=2'b01, SEL_LEFT=2'b10, SEL_LOAD=2'b11;
  - the default-parameter constants.
- One sub-module, step_prescaler:
  - inputs: DIV-parameterised counter, enable, sync clear;
  - output: step-cycle indication.
- Shift datapath, flags and MOVES live in the top module.

## Test plan
- WIDTH=8, DIV=4; pulse CLEAR low mid-shift → all outputs 0 immediately, SROUT=0x00, MOVES=0.
- Load SRIN=0x81, then SEL=01, SIR=0 for 8 cycles:
  - SROUT=0x81 until the 4th shift cycle, then 0x40 with SOR=1, STEP=1, LOST=1;
  - 0x20 after cycle 8;
  - MOVES=2.
- Load 0x01, SEL=10, SIL=1, DIV=1 → SROUT 0x03, 0x07, 0x0F on successive cycles; SOL=0, LOST=0.
- After LOST=1, SEL=11, SRIN=0x10 → LOST=0, MOVES=0, SROUT=0x10. Then SEL=00 for 10 cycles → all hold.
- MOVE_W=2, DIV=1, 6 right steps from 0x00 → MOVES saturates at 3.
- With BIDSHIFT_ROTATE_EN, ROT=1, load 0x01, DIV=1, SEL=01 → 0x80 with SOR=1, LOST stays 0; 8 steps return SROUT to 0x01.

Source files
------------

// File: rtl/bidshift_pkg.sv
// Shared constants for the bidshift_stepper LED-row shift register:
// SEL operation encodings and default parameter values.
package bidshift_pkg;

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_RIGHT = 2'b01;
   localparam logic [1:0] SEL_LEFT  = 2'b10;
   localparam logic [1:0] SEL_LOAD  = 2'b11;

   localparam int WIDTH_DEF  = 8;
   localparam int DIV_DEF    = 4;
   localparam int MOVE_W_DEF = 8;

endpackage

// File: rtl/step_prescaler.sv
// Step-rate prescaler: counts 0..DIV-1 while enabled and flags the cycle
// on which the counter sits at DIV-1 (the step cycle). A synchronous clear
// (used on parallel load) restarts the count from zero. When not enabled
// the count holds, so a direction change or a pause resumes mid-count.
module step_prescaler
   import bidshift_pkg::*;
#(
   parameter int DIV = DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic step
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count_r;
   logic [CW-1:0] count_s;

   assign step = enable && (count_r == LAST);

   // Next count: clear wins, wrap at the step cycle, otherwise advance or hold.
   always_comb begin
      count_s = count_r;
      if (clear) begin
         count_s = {CW{1'b0}};
      end else if (enable) begin
         if (count_r == LAST) begin
            count_s = {CW{1'b0}};
         end else begin
            count_s = count_r + CW'(1);
         end
      end else begin
         count_s = count_r;
      end
   end

   // Prescaler count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CW{1'b0}};
      end else begin
         count_r <= count_s;
      end
   end

endmodule

// File: rtl/bidshift_stepper.sv
// Bidirectional stepping shift register for the playfield LED row.
// Shifts left/right at a prescaled rate, loads in parallel, reports the
// bits falling off either end, keeps a sticky ball-lost flag and a
// saturating move counter. All outputs are registered.
// Optional feature macro: BIDSHIFT_ROTATE_EN (ROT=1 turns shifts into
// rotations that never set LOST); without it ROT is ignored.
module bidshift_stepper
   import bidshift_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DIV    = DIV_DEF,
   parameter int MOVE_W = MOVE_W_DEF
) (
   input  logic              CK,
   input  logic              CLEAR,
   input  logic [WIDTH-1:0]  SRIN,
   input  logic [1:0]        SEL,
   input  logic              SIL,
   input  logic              SIR,
   input  logic              ROT,
   output logic [WIDTH-1:0]  SROUT,
   output logic              SOR,
   output logic              SOL,
   output logic              STEP,
   output logic              LOST,
   output logic [MOVE_W-1:0] MOVES
);

   localparam logic [MOVE_W-1:0] MOVES_MAX = {MOVE_W{1'b1}};

   logic              rot_s;
   logic              shift_en_s;
   logic              load_s;
   logic              step_s;
   logic              in_bit_s;
   logic [WIDTH-1:0]  sr_s;
   logic              sor_s;
   logic              sol_s;
   logic              step_out_s;
   logic              lost_s;
   logic [MOVE_W-1:0] moves_s;

`ifdef BIDSHIFT_ROTATE_EN
   assign rot_s = ROT;
`else
   logic unused_rot_s;
   assign unused_rot_s = ROT;
   assign rot_s        = 1'b0;
`endif

   assign shift_en_s = (SEL == SEL_RIGHT) || (SEL == SEL_LEFT);
   assign load_s     = (SEL == SEL_LOAD);

   step_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk    (CK),
      .rst_n  (CLEAR),
      .enable (shift_en_s),
      .clear  (load_s),
      .step   (step_s)
   );

   // Next register contents, end-bit pulses, lost flag and move count.
   always_comb begin
      sr_s       = SROUT;
      sor_s      = 1'b0;
      sol_s      = 1'b0;
      step_out_s = 1'b0;
      lost_s     = LOST;
      moves_s    = MOVES;
      in_bit_s   = 1'b0;
      case (SEL)
         SEL_LOAD: begin
            sr_s    = SRIN;
            lost_s  = 1'b0;
            moves_s = {MOVE_W{1'b0}};
         end
         SEL_RIGHT: begin
            if (step_s) begin
               in_bit_s   = rot_s ? SROUT[0] : SIR;
               sr_s       = {in_bit_s, SROUT[WIDTH-1:1]};
               sor_s      = SROUT[0];
               step_out_s = 1'b1;
               lost_s     = LOST | (SROUT[0] & ~rot_s);
               moves_s    = (MOVES == MOVES_MAX) ? MOVES : MOVES + MOVE_W'(1);
            end else begin
               sr_s = SROUT;
            end
         end
         SEL_LEFT: begin
            if (step_s) begin
               in_bit_s   = rot_s ? SROUT[WIDTH-1] : SIL;
               sr_s       = {SROUT[WIDTH-2:0], in_bit_s};
               sol_s      = SROUT[WIDTH-1];
               step_out_s = 1'b1;
               lost_s     = LOST | (SROUT[WIDTH-1] & ~rot_s);
               moves_s    = (MOVES == MOVES_MAX) ? MOVES : MOVES + MOVE_W'(1);
            end else begin
               sr_s = SROUT;
            end
         end
         default: begin
            sr_s = SROUT;
         end
      endcase
   end

   // Output registers; CLEAR abandons everything asynchronously.
   always_ff @(posedge CK or negedge CLEAR) begin
      if (!CLEAR) begin
         SROUT <= {WIDTH{1'b0}};
         SOR   <= 1'b0;
         SOL   <= 1'b0;
         STEP  <= 1'b0;
         LOST  <= 1'b0;
         MOVES <= {MOVE_W{1'b0}};
      end else begin
         SROUT <= sr_s;
         SOR   <= sor_s;
         SOL   <= sol_s;
         STEP  <= step_out_s;
         LOST  <= lost_s;
         MOVES <= moves_s;
      end
   end

endmodule
